// File: rtl/type_param_fifo_pkg.sv
// Shared types, limits and pointer helper for the type-parameterised FIFO.
package type_param_fifo_pkg;

  typedef logic [8:0] default_state_t;

  localparam int MAX_DEPTH = 16;
  localparam int MAX_PTR_W = $clog2(MAX_DEPTH);

  // Advance a ring pointer, wrapping to zero at depth-1 by compare.
  function automatic logic [MAX_PTR_W-1:0] next_ptr(
    input logic [MAX_PTR_W-1:0] ptr,
    input logic [MAX_PTR_W:0]   depth
  );
    logic [MAX_PTR_W:0] last_s;
    last_s = depth - {{MAX_PTR_W{1'b0}}, 1'b1};
    if ({1'b0, ptr} == last_s) begin
      next_ptr = {MAX_PTR_W{1'b0}};
    end else begin
      next_ptr = ptr + {{(MAX_PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/type_param_fifo_chk.sv
// Occupancy and handshake invariants for the FIFO control path.
module type_param_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] count,
  input logic             push,
  input logic             pop
);

  // Check invariants on every clock outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CNT_W'(DEPTH));
      assert (!(pop && (count == {CNT_W{1'b0}})));
      assert (!(push && (count == CNT_W'(DEPTH))));
    end
  end

endmodule

// File: rtl/type_param_fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module type_param_fifo_mem #(
  parameter type data_t = logic [8:0],
  parameter int  DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  data_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output data_t             rdata
);

  data_t mem_r [DEPTH];

  // Contents are deliberately not reset; the read side masks empty slots.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/type_param_fifo.sv
// Synchronous FIFO whose element type is a parameter carried down to storage and out to the data ports.
module type_param_fifo
  import type_param_fifo_pkg::*;
#(
  parameter type data_t = default_state_t,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  data_t            in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output data_t            out_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             we_s;
  data_t            rd_data_s;

  // Flags depend only on registered count, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (count_r != CNT_W'(DEPTH));
  assign out_valid_o = (count_r != {CNT_W{1'b0}});
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;
  assign we_s        = push_s & rst_ni & ~flush_i;
  assign count_o     = count_r;
  assign out_data_o  = out_valid_o ? rd_data_s : data_t'('0);

  assign wr_ptr_nxt_s = PTR_W'(next_ptr(MAX_PTR_W'(wr_ptr_r), (MAX_PTR_W + 1)'(DEPTH)));
  assign rd_ptr_nxt_s = PTR_W'(next_ptr(MAX_PTR_W'(rd_ptr_r), (MAX_PTR_W + 1)'(DEPTH)));

  // Pointer and occupancy registers; reset outranks flush, flush outranks handshakes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_nxt_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  type_param_fifo_mem #(
    .data_t (data_t),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (in_data_i),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  type_param_fifo_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .count (count_r),
    .push  (push_s),
    .pop   (pop_s)
  );

endmodule

// File: tb/tb_type_param_fifo.sv
// Three FIFO instances of different element types, each checked against its own queue model every cycle.
module tb_type_param_fifo;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  logic       va, ira, ova, ra;
  logic [2:0] da, oda, cnta;
  logic       vb, irb, ovb, rb, db, odb;
  logic [1:0] cntb;
  logic       vc, irc, ovc, rc;
  logic [8:0] dc, odc;
  logic [1:0] cntc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] qc[$];

  always #5 clk = ~clk;

  type_param_fifo #(.data_t(logic [2:0]), .DEPTH(4)) u_fifo_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(va), .in_ready_o(ira), .in_data_i(da),
    .out_valid_o(ova), .out_ready_i(ra), .out_data_o(oda), .count_o(cnta)
  );

  type_param_fifo #(.data_t(logic), .DEPTH(2)) u_fifo_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(vb), .in_ready_o(irb), .in_data_i(db),
    .out_valid_o(ovb), .out_ready_i(rb), .out_data_o(odb), .count_o(cntb)
  );

  type_param_fifo #(.DEPTH(3)) u_fifo_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(vc), .in_ready_o(irc), .in_data_i(dc),
    .out_valid_o(ovc), .out_ready_i(rc), .out_data_o(odc), .count_o(cntc)
  );

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Compare all outputs against the models, then advance models across one rising edge.
  task automatic cycle();
    logic pa, pb, pc, ga, gb, gc;
    logic [8:0] xa, xb, xc;
    check_val("a_count",     9'(cnta), 9'(qa.size()));
    check_val("a_in_ready",  9'(ira),  (qa.size() != 4) ? 9'd1 : 9'd0);
    check_val("a_out_valid", 9'(ova),  (qa.size() != 0) ? 9'd1 : 9'd0);
    check_val("a_out_data",  9'(oda),  (qa.size() != 0) ? qa[0] : 9'd0);
    check_val("b_count",     9'(cntb), 9'(qb.size()));
    check_val("b_in_ready",  9'(irb),  (qb.size() != 2) ? 9'd1 : 9'd0);
    check_val("b_out_valid", 9'(ovb),  (qb.size() != 0) ? 9'd1 : 9'd0);
    check_val("b_out_data",  9'(odb),  (qb.size() != 0) ? qb[0] : 9'd0);
    check_val("c_count",     9'(cntc), 9'(qc.size()));
    check_val("c_in_ready",  9'(irc),  (qc.size() != 3) ? 9'd1 : 9'd0);
    check_val("c_out_valid", 9'(ovc),  (qc.size() != 0) ? 9'd1 : 9'd0);
    check_val("c_out_data",  odc,      (qc.size() != 0) ? qc[0] : 9'd0);
    pa = va && (qa.size() != 4);
    ga = ra && (qa.size() != 0);
    pb = vb && (qb.size() != 2);
    gb = rb && (qb.size() != 0);
    pc = vc && (qc.size() != 3);
    gc = rc && (qc.size() != 0);
    xa = 9'(da);
    xb = 9'(db);
    xc = dc;
    @(posedge clk);
    if (!rst_n || flush) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      if (ga) void'(qa.pop_front());
      if (pa) qa.push_back(xa);
      if (gb) void'(qb.pop_front());
      if (pb) qb.push_back(xb);
      if (gc) void'(qc.pop_front());
      if (pc) qc.push_back(xc);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    va = 1'b0; ra = 1'b0; da = 3'd0;
    vb = 1'b0; rb = 1'b0; db = 1'b0;
    vc = 1'b0; rc = 1'b0; dc = 9'd0;
    @(negedge clk);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    check_val("reset_count_a", 9'(cnta), 9'd0);
    check_val("reset_ready_a", 9'(ira), 9'd1);

    // Scenario 1 on all three types: fill with output stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; da = 3'(i + 1);
      vb = (i < 2); db = (i == 0);
      vc = (i < 3); dc = 9'(9'h0A5 + 9'(i * 37));
      cycle();
    end
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    check_val("s1_count_full", 9'(cnta), 9'd4);
    check_val("s1_ready_full", 9'(ira), 9'd0);
    check_val("s1_head", 9'(oda), 9'd1);
    check_val("s1_b_full", 9'(irb), 9'd0);
    check_val("s1_c_head", odc, 9'h0A5);
    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    repeat (4) cycle();
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    check_val("s1_count_empty", 9'(cnta), 9'd0);
    check_val("s1_data_empty", 9'(oda), 9'd0);
    cycle();

    // Scenario 2: single-bit stream with consumer always ready.
    rb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vb = 1'b1; db = ~i[0];
      cycle();
      check_val("s2_count_le1", (cntb <= 2'd1) ? 9'd1 : 9'd0, 9'd1);
    end
    vb = 1'b0;
    cycle();
    rb = 1'b0;

    // Scenario 3: depth-3 streaming with both sides held ready, wrapping pointers.
    rc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vc = 1'b1; dc = 9'($urandom_range(511, 0));
      cycle();
    end
    vc = 1'b0;
    cycle();
    rc = 1'b0;
    check_val("s3_drained", 9'(cntc), 9'd0);

    // Scenario 4: full, push attempt plus pop in the same cycle.
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; da = 3'(i + 5);
      cycle();
    end
    da = 3'd3; ra = 1'b1;
    cycle();
    va = 1'b0; ra = 1'b0;
    check_val("s4_count", 9'(cnta), 9'd3);
    check_val("s4_ready", 9'(ira), 9'd1);
    check_val("s4_head", 9'(oda), 9'd6);
    ra = 1'b1;
    repeat (3) cycle();
    ra = 1'b0;

    // Scenario 5: flush at count 2 beats a simultaneous push and pop.
    va = 1'b1;
    for (int i = 0; i < 2; i++) begin
      da = 3'(i + 2);
      cycle();
    end
    flush = 1'b1; ra = 1'b1; da = 3'd7;
    cycle();
    flush = 1'b0; va = 1'b0; ra = 1'b0;
    check_val("s5_count", 9'(cnta), 9'd0);
    check_val("s5_valid", 9'(ova), 9'd0);
    check_val("s5_data", 9'(oda), 9'd0);
    cycle();

    // Scenario 6: reset mid-operation at count 3, with flush also raised.
    va = 1'b1;
    for (int i = 0; i < 3; i++) begin
      da = 3'(i + 1);
      cycle();
    end
    rst_n = 1'b0; flush = 1'b1; da = 3'd4;
    cycle();
    rst_n = 1'b1; flush = 1'b0; va = 1'b0;
    check_val("s6_count", 9'(cnta), 9'd0);
    check_val("s6_ready", 9'(ira), 9'd1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/type_param_fifo.md
Name: type_param_fifo

Overview:
- Type-parameterised synchronous FIFO, one stage upstream of the type-parameterised state consumer.
- Buffers values of a caller-supplied type. Its data output port is declared with the same type parameter, so it can be wired directly to a consumer's typed input port.
- Exercises type parameters used as storage element type, as port type and in casts, across several instantiations with different types in one parent.

Parameters:
- data_t, logic [8:0]: element type; any packed type, including single-bit logic and typedef'd vectors.
- DEPTH, 4: number of entries; legal range 2..16; any value in range, not restricted to powers of two.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count; localparam, not overridable.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- flush_i  input  1  synchronous clear of contents.
- in_valid_i  input  1  producer has data.
- in_ready_o  output  1  FIFO can accept data.
- in_data_i  input  $bits(data_t)  element in; port type is data_t.
- out_valid_o  output  1  FIFO holds data.
- out_ready_i  input  1  consumer takes data.
- out_data_o  output  $bits(data_t)  head element; port type is data_t.
- count_o  output  CNT_W  current occupancy.

Behaviour:
- Reset: while rst_ni=0 at a rising edge:
  - wr_ptr, rd_ptr and count clear to 0.
  - out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=data_t'('0).
  - Storage array is not reset.
- Reset mid-operation discards all contents; no pending handshake completes on that edge.
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_valid_i may assert regardless of in_ready_o; the producer holds data until accepted.
- Flags, combinational from registered count:
  - in_ready_o = (count != DEPTH).
  - out_valid_o = (count != 0).
  - No combinational path from out_ready_i to in_ready_o.
- out_data_o:
  - = mem[rd_ptr] when out_valid_o=1.
  - = data_t'('0) when empty; no X ever visible.
- Latency: an element pushed at edge N is visible on out_data_o with out_valid_o=1 after edge N. There is no same-cycle fall-through.
- Pointer update:
  - Pointers advance by 1 on their respective event.
  - At DEPTH-1 a pointer wraps to 0 by explicit compare, not by bit truncation.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Neither: hold.
- Boundary conditions:
  - Full: in_ready_o=0, so no push. A pop still occurs; in_ready_o rises the following cycle.
  - Empty: no pop possible. A push with out_ready_i=1 is not consumed that cycle.
  - Simultaneous push and pop at count=1: count stays 1 and head moves to the new element.
- Flush:
  - flush_i=1 at an edge (with rst_ni=1) behaves like reset for pointers and count.
  - Flush has priority over push and pop in the same cycle; the pushed element is dropped.
- Reset has priority over flush.
- No overflow or underflow is possible by construction. Assertions: count<=DEPTH; no pop when empty; no push when full.

Decomposition:
- type_param_fifo_pkg:
  - typedef logic [8:0] default_state_t.
  - Localparam MAX_DEPTH=16.
  - Function next_ptr(ptr, depth), used for wrap-around.
- One sub-module, type_param_fifo_mem:
  - Parameters data_t and DEPTH.
  - Write port (we, waddr, wdata of type data_t).
  - Asynchronous read port (raddr, rdata of type data_t).
  - Keeps the type parameter flowing through two hierarchy levels.

Test Plan:
1. data_t=logic [2:0], DEPTH=4. Push 3'd1,2,3,4 with out_ready_i=0 → count_o=4, in_ready_o=0, out_data_o=3'd1. Then pop 4 → outputs 1,2,3,4 in order; count_o=0; out_data_o=0.
2. data_t=logic (1-bit), DEPTH=2. Alternate push 1/0 with out_ready_i=1 continuously → each bit appears one cycle after push; count_o never exceeds 1.
3. DEPTH=3 (non-power-of-two). Push/pop 10 elements with in_valid_i, out_ready_i both held 1 → pointers wrap 2→0; output sequence equals input sequence.
4. Full at DEPTH=4, push attempt plus pop in same cycle → push rejected; count_o 4→3; in_ready_o=1 next cycle.
5. Count=2, assert flush_i with in_valid_i=1 and out_ready_i=1 → next cycle count_o=0, out_valid_o=0, out_data_o=0.
6. Count=3, drive rst_ni=0 for one edge → count_o=0, in_ready_o=1. Three instances in one parent (logic, logic [2:0], default) elaborate and pass scenario 1 independently.
